dcache_ctrl: RTL and testbench

- Sequencing controller for the direct-mapped, one-word-per-line data cache in front of data memory in the RV32I core.
- Owns the tag/valid/data arrays. Performs the hit/miss lookup and stalls the pipeline on a miss.
- Runs read refills and write-through stores against a handshaked memory port.
- Provides a flush and hit/miss statistics counters.

---
 rtl/dcache_ctrl.sv | 163 ++++++++++++++++
 tb/tb_dcache_ctrl.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// ============================================================================
//  Module   : dcache_ctrl
//  Purpose  : Direct-mapped, one-word-per-line write-through data cache controller
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 30,
    parameter int SET_BITS      = 3,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0]    cpu_wdata,
    output logic [DATA_WIDTH-1:0]    cpu_rdata,
    output logic                     cpu_stall,
    input  logic                     flush,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    input  logic                     mem_ack,
    output logic [CNT_WIDTH-1:0]     hit_count,
    output logic [CNT_WIDTH-1:0]     miss_count
);

    localparam int LINES = 1 << SET_BITS;
    localparam int TAG_W = ADDRESS_WIDTH - SET_BITS;

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_refill = 2'd1;
    localparam logic [1:0] c_st_write  = 2'd2;

    localparam logic [CNT_WIDTH-1:0] c_cnt_max = {CNT_WIDTH{1'b1}};

    logic [1:0]            state_q, state_d;
    logic [LINES-1:0]      valid_q, valid_d;
    logic [TAG_W-1:0]      tag_mem_q  [LINES];
    logic [TAG_W-1:0]      tag_mem_d  [LINES];
    logic [DATA_WIDTH-1:0] data_mem_q [LINES];
    logic [DATA_WIDTH-1:0] data_mem_d [LINES];
    logic [CNT_WIDTH-1:0]  hit_count_q, hit_count_d;
    logic [CNT_WIDTH-1:0]  miss_count_q, miss_count_d;

    logic [SET_BITS-1:0]   w_index;
    logic [TAG_W-1:0]      w_tag;
    logic                  w_hit;
    logic                  w_lookup;

    assign w_index  = cpu_addr[SET_BITS-1:0];
    assign w_tag    = cpu_addr[ADDRESS_WIDTH-1:SET_BITS];
    assign w_hit    = valid_q[w_index] && (tag_mem_q[w_index] == w_tag);
    // A pending flush pre-empts the lookup for this cycle.
    assign w_lookup = (state_q == c_st_idle) && cpu_req && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= c_st_idle;
            valid_q      <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    // Line storage is never reset; a line is only meaningful while its valid bit is set.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            tag_mem_q  <= tag_mem_d;
            data_mem_q <= data_mem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_idle: begin
                if (w_lookup) begin
                    if (cpu_we)      state_d = c_st_write;
                    else if (!w_hit) state_d = c_st_refill;
                end
            end
            c_st_refill, c_st_write: begin
                if (mem_ack) state_d = c_st_idle;
            end
            default: state_d = c_st_idle;
        endcase
    end

    always_comb begin
        cpu_stall = 1'b0;
        cpu_rdata = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            c_st_idle: begin
                if (cpu_req) begin
                    if (flush || cpu_we || !w_hit) cpu_stall = 1'b1;
                    else                           cpu_rdata = data_mem_q[w_index];
                end
            end
            c_st_refill: begin
                mem_req   = 1'b1;
                mem_addr  = cpu_addr;
                cpu_stall = !mem_ack;
                if (mem_ack) cpu_rdata = mem_rdata;
            end
            c_st_write: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                cpu_stall = !mem_ack;
            end
            default: ;
        endcase
    end

    always_comb begin
        valid_d      = valid_q;
        tag_mem_d    = tag_mem_q;
        data_mem_d   = data_mem_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if ((state_q == c_st_idle) && flush) begin
            valid_d = '0;
        end
        if (w_lookup && !cpu_we) begin
            if (w_hit) begin
                if (hit_count_q != c_cnt_max) hit_count_d = hit_count_q + 1'b1;
            end else begin
                if (miss_count_q != c_cnt_max) miss_count_d = miss_count_q + 1'b1;
            end
        end
        if ((state_q == c_st_refill) && mem_ack) begin
            valid_d[w_index]    = 1'b1;
            tag_mem_d[w_index]  = w_tag;
            data_mem_d[w_index] = mem_rdata;
        end
        // No-write-allocate: a store only refreshes a line that already holds it.
        if ((state_q == c_st_write) && mem_ack && w_hit) begin
            data_mem_d[w_index] = cpu_wdata;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

endmodule

`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
// ============================================================================
//  Module   : tb_dcache_ctrl
//  Purpose  : Randomized self-checking bench for dcache_ctrl against a line-level model
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dcache_ctrl;

    localparam int DW   = 32;
    localparam int AW   = 30;
    localparam int SB   = 3;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam int NSET = 1 << SB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          flush;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic [CW-1:0] hit_count;
    logic [CW-1:0] miss_count;

    dcache_ctrl #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .SET_BITS      (SB),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: backing memory plus what each cache line holds.
    logic [DW-1:0] mem_model [64];
    bit            cv        [NSET];
    int            ctag      [NSET];
    logic [DW-1:0] cdata     [NSET];
    int            exp_hits;
    int            exp_misses;

    function automatic bit mhit(input int a);
        return cv[a % NSET] && (ctag[a % NSET] == a / NSET);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NSET; i++) cv[i] = 1'b0;
    endtask

    task automatic model_update(input bit we, input int a, input logic [DW-1:0] wd);
        if (!we) begin
            if (mhit(a)) begin
                if (exp_hits < CMAX) exp_hits++;
            end else begin
                if (exp_misses < CMAX) exp_misses++;
                cv[a % NSET]    = 1'b1;
                ctag[a % NSET]  = a / NSET;
                cdata[a % NSET] = mem_model[a];
            end
        end else begin
            mem_model[a] = wd;
            if (mhit(a)) cdata[a % NSET] = wd;
        end
    endtask

    // Drives one access and acts as the memory (acks after dly busy cycles).
    // Called and returning at 1 time unit after a rising edge.
    task automatic access(input bit we, input int a, input logic [DW-1:0] wd, input int dly,
                          output int stalls, output logic [DW-1:0] rd,
                          output bit bus_ok, output bit to);
        bit done;
        stalls    = 0;
        rd        = '0;
        bus_ok    = 1'b1;
        to        = 1'b1;
        done      = 1'b0;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = AW'(a);
        cpu_wdata = wd;
        for (int c = 0; c < 40 && !done; c++) begin
            if (c == dly + 1) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_model[a];
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end
            @(negedge clk);
            if (c == 0) begin
                if (mem_req !== 1'b0) bus_ok = 1'b0;
            end else begin
                if (mem_req !== 1'b1 || mem_we !== we || mem_addr !== AW'(a)) bus_ok = 1'b0;
                if (we && mem_wdata !== wd) bus_ok = 1'b0;
            end
            if (cpu_stall === 1'b0) begin
                rd   = cpu_rdata;
                done = 1'b1;
                to   = 1'b0;
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        mem_ack = 1'b0;
        cpu_req = 1'b0;
    endtask

    task automatic flush_cycle(input int a, output logic st, output logic mr);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = AW'(a);
        flush    = 1'b1;
        @(negedge clk);
        st = cpu_stall;
        mr = mem_req;
        @(posedge clk);
        #1;
        flush   = 1'b0;
        cpu_req = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        cpu_req = 1'b0;
        flush   = 1'b0;
        mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (cpu_stall !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0 || cpu_rdata !== '0) begin
            errors++;
            $display("FAIL reset_outputs stall=%b mem_req=%b mem_we=%b rdata=%h required 0 0 0 0",
                     cpu_stall, mem_req, mem_we, cpu_rdata);
        end
        checks++;
        if (hit_count !== '0 || miss_count !== '0) begin
            errors++;
            $display("FAIL reset_counters hit=%0d miss=%0d required 0 0", hit_count, miss_count);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    task automatic test_hit_miss();
        int st; logic [DW-1:0] rd; bit ok, to;
        mem_model[16] = 32'hDEADBEEF;
        access(1'b0, 16, '0, 2, st, rd, ok, to);
        model_update(1'b0, 16, '0);
        checks++;
        if (st !== 3 || to) begin
            errors++;
            $display("FAIL miss_stall stall_cycles=%0d timeout=%0d required 3", st, to);
        end
        checks++;
        if (rd !== 32'hDEADBEEF || !ok) begin
            errors++;
            $display("FAIL miss_rdata rdata=%h bus_ok=%0d required deadbeef 1", rd, ok);
        end
        checks++;
        if (miss_count !== CW'(exp_misses)) begin
            errors++;
            $display("FAIL miss_count got=%0d required %0d", miss_count, exp_misses);
        end
        access(1'b0, 16, '0, 0, st, rd, ok, to);
        model_update(1'b0, 16, '0);
        checks++;
        if (st !== 0 || rd !== 32'hDEADBEEF || to) begin
            errors++;
            $display("FAIL hit_rdata stall_cycles=%0d rdata=%h required 0 deadbeef", st, rd);
        end
        checks++;
        if (hit_count !== CW'(exp_hits)) begin
            errors++;
            $display("FAIL hit_count got=%0d required %0d", hit_count, exp_hits);
        end
    endtask

    task automatic test_conflict();
        int st; logic [DW-1:0] rd; bit ok, to;
        int seq [2] = '{24, 16};
        for (int i = 0; i < 2; i++) begin
            access(1'b0, seq[i], '0, 1, st, rd, ok, to);
            checks++;
            if (st !== 2 || !ok || rd !== mem_model[seq[i]]) begin
                errors++;
                $display("FAIL conflict_miss addr=%h stall_cycles=%0d bus_ok=%0d rdata=%h required 2 1 %h",
                         seq[i], st, ok, rd, mem_model[seq[i]]);
            end
            model_update(1'b0, seq[i], '0);
        end
        checks++;
        if (miss_count !== 3) begin
            errors++;
            $display("FAIL conflict_count got=%0d required 3", miss_count);
        end
    endtask

    task automatic test_store();
        int st; logic [DW-1:0] rd; bit ok, to;
        access(1'b1, 16, 32'h12345678, 3, st, rd, ok, to);
        model_update(1'b1, 16, 32'h12345678);
        checks++;
        if (st !== 4 || !ok || to) begin
            errors++;
            $display("FAIL store_bus stall_cycles=%0d bus_ok=%0d required 4 1", st, ok);
        end
        access(1'b0, 16, '0, 2, st, rd, ok, to);
        model_update(1'b0, 16, '0);
        checks++;
        if (st !== 0 || rd !== 32'h12345678) begin
            errors++;
            $display("FAIL store_hit_update stall_cycles=%0d rdata=%h required 0 12345678", st, rd);
        end
        access(1'b1, 33, 32'hCAFE0021, 0, st, rd, ok, to);
        model_update(1'b1, 33, 32'hCAFE0021);
        access(1'b0, 33, '0, 1, st, rd, ok, to);
        model_update(1'b0, 33, '0);
        checks++;
        if (st !== 2 || rd !== 32'hCAFE0021) begin
            errors++;
            $display("FAIL store_no_allocate stall_cycles=%0d rdata=%h required 2 cafe0021", st, rd);
        end
    endtask

    task automatic test_flush();
        int st; logic [DW-1:0] rd; bit ok, to; logic fs, fm;
        int hits_before;
        hits_before = exp_hits;
        flush_cycle(16, fs, fm);
        checks++;
        if (fs !== 1'b1 || fm !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall stall=%b mem_req=%b required 1 0", fs, fm);
        end
        checks++;
        if (hit_count !== CW'(hits_before)) begin
            errors++;
            $display("FAIL flush_counter hit=%0d required %0d", hit_count, hits_before);
        end
        access(1'b0, 16, '0, 1, st, rd, ok, to);
        model_update(1'b0, 16, '0);
        checks++;
        if (st !== 2 || rd !== mem_model[16] || miss_count !== CW'(exp_misses)) begin
            errors++;
            $display("FAIL flush_then_miss stall_cycles=%0d rdata=%h miss=%0d required 2 %h %0d",
                     st, rd, miss_count, mem_model[16], exp_misses);
        end
    endtask

    task automatic test_reset_mid_refill();
        int st; logic [DW-1:0] rd; bit ok, to;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = AW'(63);
        mem_ack  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL refill_started mem_req=%b required 1", mem_req);
        end
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        cpu_req = 1'b0;
        model_clear();
        exp_hits   = 0;
        exp_misses = 0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || cpu_stall !== 1'b0 || hit_count !== '0 || miss_count !== '0) begin
            errors++;
            $display("FAIL reset_mid_refill mem_req=%b stall=%b hit=%0d miss=%0d required 0 0 0 0",
                     mem_req, cpu_stall, hit_count, miss_count);
        end
        @(posedge clk);
        #1;
        access(1'b0, 63, '0, 0, st, rd, ok, to);
        model_update(1'b0, 63, '0);
        checks++;
        if (st !== 1 || rd !== mem_model[63]) begin
            errors++;
            $display("FAIL reset_then_miss stall_cycles=%0d rdata=%h required 1 %h", st, rd, mem_model[63]);
        end
    endtask

    task automatic test_saturation();
        int st; logic [DW-1:0] rd; bit ok, to;
        for (int i = 0; i < 21; i++) begin
            access(1'b0, 5, '0, 0, st, rd, ok, to);
            model_update(1'b0, 5, '0);
        end
        checks++;
        if (hit_count !== 4'd15) begin
            errors++;
            $display("FAIL hit_saturation got=%0d required 15", hit_count);
        end
    endtask

    task automatic test_random();
        int st; logic [DW-1:0] rd; bit ok, to; logic fs, fm;
        for (int n = 0; n < 150; n++) begin
            int            a;
            bit            we;
            int            dly;
            logic [DW-1:0] wd;
            bit            eh;
            logic [DW-1:0] erd;
            int            est;
            a   = $urandom_range(0, 63);
            we  = ($urandom_range(0, 3) == 0);
            dly = $urandom_range(0, 3);
            wd  = $urandom;
            if ($urandom_range(0, 9) == 0) begin
                flush_cycle(a, fs, fm);
                checks++;
                if (fs !== 1'b1 || fm !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_flush n=%0d stall=%b mem_req=%b required 1 0", n, fs, fm);
                end
            end
            eh  = mhit(a);
            erd = eh ? cdata[a % NSET] : mem_model[a];
            est = (!we && eh) ? 0 : dly + 1;
            access(we, a, wd, dly, st, rd, ok, to);
            model_update(we, a, wd);
            checks++;
            if (st !== est || !ok || to || (!we && rd !== erd)) begin
                errors++;
                $display("FAIL rand_access n=%0d we=%0d addr=%h stall_cycles=%0d bus_ok=%0d rdata=%h required %0d 1 %h",
                         n, we, a, st, ok, rd, est, erd);
            end
            checks++;
            if (hit_count !== CW'(exp_hits) || miss_count !== CW'(exp_misses)) begin
                errors++;
                $display("FAIL rand_counters n=%0d hit=%0d miss=%0d required %0d %0d",
                         n, hit_count, miss_count, exp_hits, exp_misses);
            end
        end
    endtask

    initial begin
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        flush     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        rst_n     = 1'b0;
        for (int i = 0; i < 64; i++) mem_model[i] = $urandom;
        for (int i = 0; i < NSET; i++) begin
            ctag[i]  = 0;
            cdata[i] = '0;
        end
        @(posedge clk);
        #1;
        test_reset();
        test_hit_miss();
        test_conflict();
        test_store();
        test_flush();
        test_reset_mid_refill();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
